n_wr_ctrl: RTL and testbench
============================

Name: n_wr_ctrl

Overview:
Write-side address/strobe generator for the 4096-word echo sample buffer (dual-port RAM) that the read address counter drains. On each start it captures a frame of ADC samples and writes them to consecutive addresses from 0 to len-1. The read side then sees the samples in order. It raises busy during capture and pulses done when the frame is complete. It sits between the ADC sample pipe and RAM port A.

Parameters:
ADDR_W, 12, buffer address width; depth = 2^ADDR_W.
DATA_W, 12, sample width.

Ports:
clkin  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous, active-high reset; 1 = reset, despite the name.
start  input  1  one-cycle pulse; arms a new frame.
abort  input  1  synchronous abort of the current frame.
smp_len  input  ADDR_W  number of samples in the frame; 0 means full depth (4096); sampled on start.
din  input  DATA_W  ADC sample.
din_vld  input  1  sample strobe; one sample per high cycle.
waddr  output  ADDR_W  RAM write address.
wdata  output  DATA_W  RAM write data.
we  output  1  RAM write enable.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse when a frame completes.
wr_cnt  output  ADDR_W+1  samples written in the current or last frame.

Behaviour:
- Reset (asynchronous, while rst_n=1): state=IDLE; waddr=0, wdata=0, we=0, busy=0, done=0, wr_cnt=0, len_q=0.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - din_vld is ignored.
  - On start=1 (and abort=0): latch len_q = (smp_len==0) ? 2^ADDR_W : smp_len; clear wr_cnt; set next address to 0; busy=1 from the next cycle; go to WRITE.
  - A din_vld that arrives in the same cycle as start is NOT written.
- WRITE, on each din_vld=1:
  - Next cycle: we=1, waddr=current address, wdata=din. Latency is 1 cycle and all outputs are registered.
  - Address increments by 1 and wr_cnt increments by 1.
  - we=0 in any cycle that follows din_vld=0.
  - When the write that makes wr_cnt==len_q is issued, go to DONE.
  - Address never wraps within a frame because len_q <= 2^ADDR_W. For a full-depth frame, the internal address reaching 2^ADDR_W is don't-care and is never driven onto waddr.
- DONE: lasts exactly one cycle.
  - done=1, busy=0, we=0; then go to IDLE.
  - din_vld arriving in DONE is dropped.
  - waddr holds its last written value until the next frame.
- start while in WRITE or DONE: ignored; no re-latch of len_q.
- abort=1 in WRITE:
  - Next cycle: state=IDLE, busy=0, we=0, no done pulse; wr_cnt holds the partial count.
  - abort has priority over din_vld and start in the same cycle.
  - abort in IDLE or DONE has no effect, except that a DONE pulse already scheduled still occurs.
- Reset mid-frame: immediate return to the reset values; the partial frame is discarded.
- wr_cnt is ADDR_W+1 bits wide so that 4096 is representable.

Decomposition:
- Shared package: FSM state encoding (IDLE/WRITE/DONE), and the constants BUF_ADDR_W=12 and SMP_W=12, shared with the read counter.
- No sub-module needed; a single always block for the FSM and counters plus a registered output stage.

Test Plan:
- Reset, then start with smp_len=4 and din_vld continuous with din=0x101..0x104 -> we high for 4 cycles, waddr 0,1,2,3, wdata matches, done pulses once the cycle after the last write, wr_cnt=4, busy high for exactly 5 cycles.
- smp_len=0 with 4096 gapped samples (din_vld every 3rd cycle) -> last write at waddr=0xFFF, wr_cnt=4096, a single done, no write at address 0 after the first.
- start and din_vld both high in the same cycle, smp_len=2 -> that sample is not written; the next two samples go to addresses 0 and 1.
- abort after 5 of 10 samples, asserted together with din_vld -> the 6th sample is not written, no done, busy low next cycle, wr_cnt=5; a following start with smp_len=3 writes again from address 0.
- Second start pulse mid-frame with smp_len=1, original len 8 -> ignored; the frame completes at 8 writes.
- rst_n asserted mid-frame for a fraction of a cycle (asynchronous) -> all outputs go to 0 immediately with no clock edge; din_vld afterwards produces no we until the next start.

Source files
------------

// File: rtl/n_wr_ctrl_pkg.sv
// Shared definitions for the echo sample buffer write/read sides.
package n_wr_ctrl_pkg;

  localparam int BUF_ADDR_W = 12;
  localparam int SMP_W      = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/n_wr_ctrl_if.sv
// Frame-control and RAM port A signals between the ADC pipe and the write controller.
interface n_wr_ctrl_if
  import n_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = SMP_W
);

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] smp_len;
  logic [DATA_W-1:0] din;
  logic              din_vld;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_cnt;

  modport master (
    output start, abort, smp_len, din, din_vld,
    input  waddr, wdata, we, busy, done, wr_cnt
  );

  modport slave (
    input  start, abort, smp_len, din, din_vld,
    output waddr, wdata, we, busy, done, wr_cnt
  );

endinterface

// File: rtl/n_wr_ctrl.sv
// Write-side address/strobe generator: captures one frame of samples into
// addresses 0..len-1 of the echo buffer, with busy/done status.
module n_wr_ctrl
  import n_wr_ctrl_pkg::*;
#(
  parameter int ADDR_W = BUF_ADDR_W,
  parameter int DATA_W = SMP_W
) (
  input  logic        clkin,
  input  logic        rst_n,
  n_wr_ctrl_if.slave  bus
);

  localparam int CW = ADDR_W + 1;

  wr_state_e         state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          len_d    = (bus.smp_len == '0) ? (CW'(1) << ADDR_W) : {1'b0, bus.smp_len};
          wr_cnt_d = '0;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.din_vld) begin
          // The running count doubles as the write address: addresses start at 0.
          we_d     = 1'b1;
          waddr_d  = wr_cnt_q[ADDR_W-1:0];
          wdata_d  = bus.din;
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_d == len_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clkin or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.waddr  = waddr_q;
  assign bus.wdata  = wdata_q;
  assign bus.we     = we_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_n_wr_ctrl.sv
// Directed and random stimulus for n_wr_ctrl against a frame-level reference model.
module tb_n_wr_ctrl;
  import n_wr_ctrl_pkg::*;

  localparam int AW = 12;
  localparam int DW = 12;

  logic clkin = 1'b0;
  logic rst_n;
  always #5 clkin = ~clkin;

  n_wr_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  n_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clkin(clkin), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is "capturing" until len samples are accepted,
  // then "finishing" for one cycle. Address of a sample = samples accepted before it.
  bit m_cap, m_fin;
  int m_len, m_cnt;
  bit e_we, e_busy, e_done;
  int e_waddr, e_wdata, e_wr_cnt;
  int busy_cnt, done_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".we"},     int'(bus.we),     int'(e_we));
    chk({ctx, ".busy"},   int'(bus.busy),   int'(e_busy));
    chk({ctx, ".done"},   int'(bus.done),   int'(e_done));
    chk({ctx, ".waddr"},  int'(bus.waddr),  e_waddr);
    chk({ctx, ".wr_cnt"}, int'(bus.wr_cnt), e_wr_cnt);
    if (e_we) chk({ctx, ".wdata"}, int'(bus.wdata), e_wdata);
  endtask

  task automatic model_reset();
    m_cap = 0; m_fin = 0; m_len = 0; m_cnt = 0;
    e_we = 0; e_busy = 0; e_done = 0;
    e_waddr = 0; e_wdata = 0; e_wr_cnt = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input int len, input int d, input bit v);
    e_we = 0;
    e_done = 0;
    if (m_fin) begin
      m_fin = 0; e_busy = 0; e_done = 1;
    end else if (m_cap) begin
      if (a) begin
        m_cap = 0; e_busy = 0;
      end else if (v) begin
        e_we = 1; e_waddr = m_cnt; e_wdata = d % (1 << DW);
        m_cnt++; e_wr_cnt = m_cnt;
        if (m_cnt == m_len) begin m_cap = 0; m_fin = 1; end
      end
    end else if (s && !a) begin
      m_len = (len % (1 << AW) == 0) ? (1 << AW) : len % (1 << AW);
      m_cnt = 0; e_wr_cnt = 0; m_cap = 1; e_busy = 1;
    end
  endtask

  task automatic cyc(input string ctx, input bit s, input bit a, input int len, input int d, input bit v);
    bus.start   = s;
    bus.abort   = a;
    bus.smp_len = AW'(len);
    bus.din     = DW'(d);
    bus.din_vld = v;
    @(posedge clkin);
    model_step(s, a, len, d, v);
    #1;
    check_all(ctx);
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
  endtask

  task automatic idle(input string ctx, input int n);
    for (int i = 0; i < n; i++) cyc(ctx, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.abort = 0; bus.smp_len = '0; bus.din = '0; bus.din_vld = 0;
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(posedge clkin);
    #1;
    check_all("reset");
    rst_n = 1'b0;
    idle("post_reset", 2);

    // Basic 4-sample frame with continuous samples
    busy_cnt = 0; done_cnt = 0;
    cyc("t1_start", 1, 0, 4, 0, 0);
    for (int i = 0; i < 4; i++) cyc("t1_wr", 0, 0, 0, 'h101 + i, 1);
    idle("t1_tail", 3);
    chk("t1_busy_cycles", busy_cnt, 5);
    chk("t1_done_pulses", done_cnt, 1);

    // Full-depth frame (smp_len=0), one sample every third cycle
    busy_cnt = 0; done_cnt = 0;
    cyc("t2_start", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4096; i++) begin
      cyc("t2_gap", 0, 0, 0, int'($urandom), 0);
      cyc("t2_gap", 0, 0, 0, int'($urandom), 0);
      cyc("t2_wr", 0, 0, 0, int'($urandom_range(0, 4095)), 1);
    end
    chk("t2_last_waddr", int'(bus.waddr), 'hFFF);
    chk("t2_wr_cnt", int'(bus.wr_cnt), 4096);
    idle("t2_tail", 3);
    chk("t2_done_pulses", done_cnt, 1);

    // Sample coincident with start is dropped
    cyc("t3_start_vld", 1, 0, 2, 'h055, 1);
    cyc("t3_wr0", 0, 0, 0, 'h066, 1);
    cyc("t3_wr1", 0, 0, 0, 'h077, 1);
    idle("t3_tail", 3);

    // Abort together with the 6th sample, then a fresh 3-sample frame
    done_cnt = 0;
    cyc("t4_start", 1, 0, 10, 0, 0);
    for (int i = 0; i < 5; i++) cyc("t4_wr", 0, 0, 0, 'h200 + i, 1);
    cyc("t4_abort", 0, 1, 0, 'h2FF, 1);
    chk("t4_busy_after_abort", int'(bus.busy), 0);
    chk("t4_partial_cnt", int'(bus.wr_cnt), 5);
    idle("t4_idle", 2);
    chk("t4_no_done", done_cnt, 0);
    cyc("t4_restart", 1, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t4_wr2", 0, 0, 0, 'h300 + i, 1);
    idle("t4_tail", 3);

    // Start mid-frame ignored; start+abort+sample during DONE ignored
    done_cnt = 0;
    cyc("t5_start", 1, 0, 8, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t5_wr", 0, 0, 0, 'h400 + i, 1);
    cyc("t5_restart_ign", 1, 0, 1, 'h403, 1);
    for (int i = 4; i < 8; i++) cyc("t5_wr", 0, 0, 0, 'h400 + i, 1);
    cyc("t5_in_done", 1, 1, 5, 'h4AA, 1);
    idle("t5_tail", 3);
    chk("t5_done_pulses", done_cnt, 1);
    chk("t5_final_cnt", int'(bus.wr_cnt), 8);

    // Asynchronous reset pulse mid-frame, away from any clock edge
    cyc("t6_start", 1, 0, 6, 0, 0);
    cyc("t6_wr", 0, 0, 0, 'h501, 1);
    cyc("t6_wr", 0, 0, 0, 'h502, 1);
    #2;
    rst_n = 1'b1;
    #1;
    model_reset();
    check_all("t6_async_rst");
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cyc("t6_after_rst", 0, 0, 0, 'h510 + i, 1);

    // Random frames, aborts and sample gaps
    for (int i = 0; i < 600; i++) begin
      cyc("rand",
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 39) == 0,
          int'($urandom_range(1, 12)),
          int'($urandom_range(0, 4095)),
          $urandom_range(0, 2) != 0);
    end
    idle("rand_tail", 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
